// File: rtl/hsm_bus_sequencer_if.sv
// hsm_bus_sequencer_if
// Pi-side parallel bus bundle between the GPIO pin layer and the HSM
// frame sequencer.
//   cs        frame active from the Pi
//   strobe    one-cycle byte qualifier
//   dir_rd    1 = Pi reading the bus, 0 = Pi writing
//   bus_in    byte from the pin layer
//   bus_out   byte to the pin layer
//   bus_oe    sequencer drives the pins when 1
//   key_valid full key bank loaded
//   busy      frame in progress
//   err       sticky protocol error
// Modports: master = Pi / pin-layer side, slave = sequencer side.
interface hsm_bus_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  cs;
    logic                  strobe;
    logic                  dir_rd;
    logic [DATA_WIDTH-1:0] bus_in;
    logic [DATA_WIDTH-1:0] bus_out;
    logic                  bus_oe;
    logic                  key_valid;
    logic                  busy;
    logic                  err;

    modport master (
        output cs, strobe, dir_rd, bus_in,
        input  bus_out, bus_oe, key_valid, busy, err
    );

    modport slave (
        input  cs, strobe, dir_rd, bus_in,
        output bus_out, bus_oe, key_valid, busy, err
    );
endinterface

// File: rtl/hsm_bus_sequencer.sv
// hsm_bus_sequencer
// Frame-level controller between the Raspberry Pi parallel GPIO bus and
// the HSM XOR datapath: decodes a command byte, loads a KEY_BYTES key
// bank, XORs incoming data bytes into a BUF_DEPTH result buffer and
// drives bus direction with one turnaround cycle before Pi readback.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    hsm_bus_sequencer_if.slave (cs, strobe, dir_rd, bus_in,
//          bus_out, bus_oe, key_valid, busy, err)
// Optional build macro: HSM_KEY_ZEROIZE_EN -- clears the key bank and
// key_valid on entry to ERROR or on an aborted key load.
module hsm_bus_sequencer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned KEY_BYTES  = 4,
    parameter int unsigned BUF_DEPTH  = 8
) (
    input logic                clk,
    input logic                rst_n,
    hsm_bus_sequencer_if.slave bus
);
    localparam int unsigned KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam int unsigned AW = $clog2(BUF_DEPTH);
    localparam logic [KW-1:0] KLAST = KW'(KEY_BYTES - 1);
    localparam logic [AW:0]   BFULL = (AW + 1)'(BUF_DEPTH);
    localparam logic [DATA_WIDTH-1:0] CMD_KEY  = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] CMD_DATA = DATA_WIDTH'(2);
`ifdef HSM_KEY_ZEROIZE_EN
    localparam bit ZEROIZE = 1'b1;
`else
    localparam bit ZEROIZE = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, CMD, KEY_LOAD, DATA_IN, TURN, DATA_OUT, ERROR
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] key_bank [KEY_BYTES];
    logic [DATA_WIDTH-1:0] fifo_mem [BUF_DEPTH];
    logic [KW-1:0]         kidx;
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;
    logic                  cs_q, dir_q, err_q, key_valid_q;

    logic cs_rise, dir_rise, stb, abort, buf_full, buf_empty;
    logic push, pop, enter_err, partial_abort, oe;

    assign cs_rise   = bus.cs & ~cs_q;
    assign dir_rise  = bus.dir_rd & ~dir_q;
    assign stb       = bus.strobe & bus.cs;
    // Level check is enough: once cs is low every non-IDLE state exits.
    assign abort     = (state != IDLE) & ~bus.cs;
    assign buf_full  = (count == BFULL);
    assign buf_empty = (count == '0);
    assign push      = (state == DATA_IN) & key_valid_q & stb & ~bus.dir_rd & ~buf_full;
    assign pop       = (state == DATA_OUT) & stb & bus.dir_rd & ~buf_empty;
    assign enter_err = (state != ERROR) & (state_nxt == ERROR);
    assign partial_abort = (state == KEY_LOAD) & abort;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:     if (cs_rise) state_nxt = CMD;
                CMD: begin
                    if (stb) begin
                        if (bus.bus_in == CMD_KEY)       state_nxt = KEY_LOAD;
                        else if (bus.bus_in == CMD_DATA) state_nxt = DATA_IN;
                        else                             state_nxt = ERROR;
                    end
                end
                KEY_LOAD: if (stb && kidx == KLAST) state_nxt = CMD;
                DATA_IN: begin
                    if (!key_valid_q)  state_nxt = ERROR;
                    else if (dir_rise) state_nxt = TURN;
                end
                TURN:     state_nxt = DATA_OUT;
                DATA_OUT: if (!bus.dir_rd) state_nxt = DATA_IN;
                ERROR:    state_nxt = ERROR;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    // Outputs: bus_oe also gated by live cs/dir_rd so it drops in the
    // same cycle the Pi releases either, never overlapping its drivers.
    always_comb begin
        oe            = (state == DATA_OUT) & bus.cs & bus.dir_rd;
        bus.bus_oe    = oe;
        bus.bus_out   = '0;
        if (oe && !buf_empty) bus.bus_out = fifo_mem[rd_ptr];
        bus.busy      = (state != IDLE);
        bus.key_valid = key_valid_q;
        bus.err       = err_q;
    end

    // Key bank, key index, buffer pointers and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < KEY_BYTES; i++) key_bank[i] <= '0;
            kidx        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            cs_q        <= 1'b0;
            dir_q       <= 1'b0;
            err_q       <= 1'b0;
            key_valid_q <= 1'b0;
        end else begin
            cs_q  <= bus.cs;
            dir_q <= bus.dir_rd;
            if (abort) begin
                kidx   <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                if (state == KEY_LOAD) begin
                    key_valid_q <= 1'b0;
                    err_q       <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: if (cs_rise) err_q <= 1'b0;
                    CMD: begin
                        if (stb) begin
                            kidx <= '0;
                            if (bus.bus_in == CMD_DATA) begin
                                wr_ptr <= '0;
                                rd_ptr <= '0;
                                count  <= '0;
                            end
                        end
                    end
                    KEY_LOAD: begin
                        if (stb) begin
                            key_bank[kidx] <= bus.bus_in;
                            if (kidx == KLAST) begin
                                kidx        <= '0;
                                key_valid_q <= 1'b1;
                            end else begin
                                kidx <= kidx + KW'(1);
                            end
                        end
                    end
                    DATA_IN: begin
                        if (push) begin
                            wr_ptr <= wr_ptr + AW'(1);
                            count  <= count + (AW + 1)'(1);
                            kidx   <= (kidx == KLAST) ? '0 : kidx + KW'(1);
                        end else if (key_valid_q && stb && !bus.dir_rd && buf_full) begin
                            err_q <= 1'b1;
                        end
                    end
                    DATA_OUT: begin
                        if (pop) begin
                            rd_ptr <= rd_ptr + AW'(1);
                            count  <= count - (AW + 1)'(1);
                        end else if (stb && bus.dir_rd) begin
                            err_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
                if (enter_err) err_q <= 1'b1;
            end
            if (ZEROIZE && (enter_err || partial_abort)) begin
                for (int unsigned i = 0; i < KEY_BYTES; i++) key_bank[i] <= '0;
                key_valid_q <= 1'b0;
            end
        end
    end

    // Result buffer storage; only the pointers need a reset
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.bus_in ^ key_bank[kidx];
    end
endmodule

// File: tb/tb_hsm_bus_sequencer.sv
`timescale 1ns/1ps
module tb_hsm_bus_sequencer;
    localparam int KB = 4;
    localparam int BD = 8;

    localparam int M_IDLE = 0;
    localparam int M_CMD  = 1;
    localparam int M_KEY  = 2;
    localparam int M_DATA = 3;
    localparam int M_READ = 4;
    localparam int M_ERR  = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hsm_bus_sequencer_if #(.DATA_WIDTH(8)) bus_if ();

    hsm_bus_sequencer #(
        .DATA_WIDTH(8),
        .KEY_BYTES (KB),
        .BUF_DEPTH (BD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level reference model
    int         m_mode;
    logic [7:0] m_key [KB];
    bit         m_kv;
    bit         m_err;
    int         m_kidx;
    logic [7:0] m_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_zeroize();
`ifdef HSM_KEY_ZEROIZE_EN
        foreach (m_key[i]) m_key[i] = '0;
        m_kv = 1'b0;
`endif
    endfunction

    function automatic void model_reset();
        m_mode = M_IDLE;
        foreach (m_key[i]) m_key[i] = '0;
        m_kv   = 1'b0;
        m_err  = 1'b0;
        m_kidx = 0;
        m_q.delete();
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_status();
        check("busy", 32'(bus_if.busy), 32'(m_mode != M_IDLE));
        check("err", 32'(bus_if.err), 32'(m_err));
        check("key_valid", 32'(bus_if.key_valid), 32'(m_kv));
        check("bus_oe", 32'(bus_if.bus_oe), 32'(m_mode == M_READ));
        if (m_mode != M_READ) check("bus_out_quiet", 32'(bus_if.bus_out), 32'd0);
    endtask

    task automatic check_keys();
        for (int i = 0; i < KB; i++)
            check($sformatf("key_bank[%0d]", i), 32'(dut.key_bank[i]), 32'(m_key[i]));
    endtask

    // One strobe high across exactly one rising edge
    task automatic pulse(input logic [7:0] b);
        bus_if.bus_in = b;
        bus_if.strobe = 1'b1;
        tick();
        bus_if.strobe = 1'b0;
        bus_if.bus_in = 8'($urandom);
    endtask

    task automatic send(input logic [7:0] b);
        pulse(b);
        case (m_mode)
            M_CMD: begin
                if (b == 8'h01) begin
                    m_mode = M_KEY;
                    m_kidx = 0;
                end else if (b == 8'h02) begin
                    m_kidx = 0;
                    m_q.delete();
                    if (m_kv) m_mode = M_DATA;
                    else begin
                        m_mode = M_ERR;
                        m_err  = 1'b1;
                        model_zeroize();
                    end
                end else begin
                    m_mode = M_ERR;
                    m_err  = 1'b1;
                    model_zeroize();
                end
            end
            M_KEY: begin
                m_key[m_kidx] = b;
                m_kidx++;
                if (m_kidx == KB) begin
                    m_kv   = 1'b1;
                    m_kidx = 0;
                    m_mode = M_CMD;
                end
            end
            M_DATA: begin
                if (m_q.size() == BD) m_err = 1'b1;
                else begin
                    m_q.push_back(b ^ m_key[m_kidx]);
                    m_kidx = (m_kidx + 1) % KB;
                end
            end
            default: ;
        endcase
        check("key_valid_after_strobe", 32'(bus_if.key_valid), 32'(m_kv));
        tick();
        check_status();
    endtask

    task automatic load_key();
        send(8'h01);
        for (int j = 0; j < KB; j++) send(8'($urandom));
    endtask

    task automatic turn_on();
        bus_if.dir_rd = 1'b1;
        #1;
        check("oe_before_turn", 32'(bus_if.bus_oe), 32'd0);
        tick();
        check("oe_turnaround", 32'(bus_if.bus_oe), 32'd0);
        tick();
        m_mode = M_READ;
        check("oe_readback", 32'(bus_if.bus_oe), 32'd1);
    endtask

    task automatic read_byte();
        logic [7:0] exp;
        exp = (m_q.size() != 0) ? m_q[0] : 8'h00;
        check("read_byte", 32'(bus_if.bus_out), 32'(exp));
        pulse(8'($urandom));
        if (m_q.size() == 0) m_err = 1'b1;
        else void'(m_q.pop_front());
        tick();
        check_status();
    endtask

    task automatic turn_off();
        bus_if.dir_rd = 1'b0;
        #1;
        check("oe_drop_same_cycle", 32'(bus_if.bus_oe), 32'd0);
        tick();
        m_mode = M_DATA;
        check_status();
    endtask

    task automatic frame_start();
        bus_if.cs = 1'b1;
        tick();
        m_mode = M_CMD;
        m_err  = 1'b0;
        check_status();
    endtask

    task automatic frame_end();
        if (m_mode == M_READ) turn_off();
        bus_if.cs = 1'b0;
        #1;
        check("oe_cs_fall", 32'(bus_if.bus_oe), 32'd0);
        tick();
        if (m_mode == M_KEY) begin
            m_kv  = 1'b0;
            m_err = 1'b1;
            model_zeroize();
        end
        m_mode = M_IDLE;
        m_kidx = 0;
        m_q.delete();
        check_status();
        check_keys();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_if.cs = 1'b0;
        bus_if.strobe = 1'b0;
        bus_if.dir_rd = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        model_reset();
        check_status();
        check_keys();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "time limit");
    end

    initial begin
        int         nk, sel, nd, nr, rounds;
        logic [7:0] b;
        bus_if.bus_in = '0;
        do_reset();

        // Key load: 0x01 then four key bytes
        frame_start();
        send(8'h01);
        send(8'hA5);
        send(8'h5A);
        send(8'h0F);
        send(8'hF0);

        // Encrypt five bytes and read them back across the key wrap
        send(8'h02);
        send(8'h00);
        send(8'hFF);
        send(8'h12);
        send(8'h34);
        send(8'h56);
        turn_on();
        repeat (5) read_byte();
        frame_end();

        // cs rise with a simultaneous strobe: strobe must be ignored
        bus_if.cs = 1'b1;
        bus_if.strobe = 1'b1;
        bus_if.bus_in = 8'h01;
        tick();
        bus_if.strobe = 1'b0;
        m_mode = M_CMD;
        m_err  = 1'b0;
        check_status();
        send(8'h02);
        send(8'h3C);
        send(8'hC3);
        turn_on();
        repeat (2) read_byte();
        frame_end();

        // Encrypt with no key
        do_reset();
        frame_start();
        send(8'h02);
        send(8'h11);
        frame_end();

        // Overflow then underflow
        frame_start();
        load_key();
        send(8'h02);
        repeat (BD + 1) send(8'($urandom));
        turn_on();
        repeat (BD + 1) read_byte();
        frame_end();

        // Bad command, then an aborted key load
        frame_start();
        send(8'h7E);
        repeat (3) send(8'($urandom));
        frame_end();
        frame_start();
        send(8'h01);
        send(8'h99);
        send(8'h66);
        frame_end();

        // Reset in the middle of readback
        frame_start();
        load_key();
        send(8'h02);
        repeat (3) send(8'($urandom));
        turn_on();
        read_byte();
        rst_n = 1'b0;
        #1;
        check("rst_bus_oe", 32'(bus_if.bus_oe), 32'd0);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_bus_out", 32'(bus_if.bus_out), 32'd0);
        check("rst_key_valid", 32'(bus_if.key_valid), 32'd0);
        check("rst_err", 32'(bus_if.err), 32'd0);
        bus_if.cs = 1'b0;
        bus_if.dir_rd = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        model_reset();
        check_status();
        check_keys();
        frame_start();
        load_key();
        send(8'h02);
        turn_on();
        read_byte();
        frame_end();

        // Randomized frames
        for (int f = 0; f < 150; f++) begin
            if ($urandom_range(0, 7) == 0) begin
                pulse(8'($urandom));
                tick();
                check_status();
                check_keys();
            end
            frame_start();
            nk = $urandom_range(0, 2);
            for (int k = 0; k < nk; k++) load_key();
            sel = $urandom_range(0, 9);
            if (sel < 6) begin
                send(8'h02);
                if (m_mode == M_DATA) begin
                    rounds = $urandom_range(1, 2);
                    for (int r = 0; r < rounds; r++) begin
                        nd = $urandom_range(0, 10);
                        for (int d = 0; d < nd; d++) send(8'($urandom));
                        turn_on();
                        nr = $urandom_range(0, 10);
                        for (int d = 0; d < nr; d++) read_byte();
                        turn_off();
                    end
                end
            end else if (sel == 6) begin
                b = 8'($urandom);
                if (b == 8'h01 || b == 8'h02) b = 8'h7E;
                send(b);
                nd = $urandom_range(0, 3);
                for (int d = 0; d < nd; d++) send(8'($urandom));
            end else if (sel == 7) begin
                send(8'h01);
                nd = $urandom_range(0, KB - 1);
                for (int d = 0; d < nd; d++) send(8'($urandom));
            end
            frame_end();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
